mux_rr_sched: RTL and testbench
===============================

Name: mux_rr_sched

Overview:
- Round-robin scheduler that shares the 16:1 function mux (select S1..S4, S1 = MSB) between 16 requesters.
- Picks one requester at a time and drives the mux select lines, holding them stable for the grant.
- Inserts a one-cycle break-before-make gap between owners.
- Sits directly in front of mux_fun; owner k reads mux output O, which then reflects I[k].

Parameters:
- DWELL, 4: minimum cycles a grant is held before done is honoured (1..MAX_HOLD).
- MAX_HOLD, 16: grant timeout in cycles; forced release at expiry (>= DWELL).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- req  input  16  request per requester; req[k] asks for mux input k
- done  input  1  current owner releases the mux
- S1  output  1  select bit 3 (MSB) to mux
- S2  output  1  select bit 2
- S3  output  1  select bit 1
- S4  output  1  select bit 0 (LSB)
- grant  output  16  one-hot grant; all-zero when idle or in gap
- valid  output  1  a grant is active, and {S1,S2,S3,S4} = granted index
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Reset (async, immediate):
  - state = IDLE; {S1,S2,S3,S4} = 0; grant = 0; valid = 0; timeout = 0.
  - Internal last pointer = 15, so the first search starts at index 0.
  - Hold counter = 0.
- All outputs are registered. No combinational path from req or done to any output.
- States: IDLE, OWN, GAP.
- IDLE:
  - If req != 0, select the first set bit scanning last+1, last+2, ... mod 16, with wrap-around (15 -> 0).
  - Next edge: register sel = winner, grant = 1<<winner, valid = 1, last = winner, counter = 0, state = OWN.
  - Latency: req sampled at edge n gives grant visible after edge n (one cycle).
  - If req == 0, stay in IDLE; sel holds its last value unless MUX_SCAN_EN is defined.
- OWN:
  - The counter increments each cycle, saturating at MAX_HOLD-1.
  - Release when any of these holds:
    - (a) done = 1 and counter >= DWELL-1;
    - (b) req[sel] = 0, i.e. the requester withdrew (honoured regardless of DWELL);
    - (c) counter == MAX_HOLD-1, which also gives timeout = 1 for the cycle after the release edge.
  - On release: grant = 0, valid = 0, state = GAP; sel is unchanged during GAP.
  - done asserted before DWELL is ignored and is not remembered.
- GAP:
  - Exactly one cycle with no grant.
  - Then return to IDLE, where arbitration resumes on the following edge.
  - Minimum owner-to-owner spacing is therefore 2 idle cycles.
- Fairness:
  - The last winner has lowest priority next round.
  - A requester re-asserting immediately after release is served only after every other pending requester.
- Simultaneous events:
  - done and timeout expiry in the same cycle: treated as timeout, and the pulse is asserted.
  - req[sel] dropping together with done: normal release, no timeout.
- The grant is always one-hot or zero. valid == |grant at all times.
- Reset mid-grant drops grant/valid immediately (asynchronous); the arbitration pointer returns to 15.

Optional Feature:
- Macro: MUX_SCAN_EN.
- Defined: in IDLE with req == 0, {S1,S2,S3,S4} increments by 1 each cycle (15 wraps to 0), sweeping the mux inputs for observation.
  - grant and valid stay 0 while sweeping.
  - The last pointer is not affected by the sweep.
  - Arbitration on a new request is unchanged.
- Not defined: sel holds the last granted index while idle.

Test Plan:
- Single request: reset, then req = 16'h0020 -> one cycle later grant = 16'h0020, {S1..S4} = 4'b0101, valid = 1; with I = 16'hAAAA the mux O = 1.
- Round-robin order: req = 16'h8001 held, done pulsed after DWELL each grant -> grants alternate 0, 15, 0, 15, ...
  - valid low for exactly 2 cycles between grants (GAP + IDLE).
- Early done ignored: DWELL = 4, done = 1 on counter 0..2 then 0 -> grant persists.
  - With done = 1 at counter 3 -> release on that edge.
- Timeout: req = 16'h0100 held, done never asserted, MAX_HOLD = 16 -> grant stays 16 cycles.
  - Then grant = 0 and timeout pulses high for 1 cycle.
  - Index 8 is re-granted after the gap.
- Withdrawal and reset: requester 3 granted, req[3] drops at counter 1 -> release next edge with no timeout.
  - Assert rst mid-grant -> grant = 0, sel = 0 immediately.
  - After rst release with req = 16'hFFFF, the first grant is index 0.
- MUX_SCAN_EN defined, req = 0 for 20 cycles -> {S1..S4} steps 0, 1, ..., 15, 0, 1, ... with valid = 0 throughout.

Source files
------------

// File: rtl/mux_rr_sched.sv
// Round-robin owner scheduler in front of the 16:1 function mux.
// Optional idle select sweep: define MUX_SCAN_EN.
module mux_rr_sched #(
    parameter int DWELL    = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic        S1,
    output logic        S2,
    output logic        S3,
    output logic        S4,
    output logic [15:0] grant,
    output logic        valid,
    output logic        timeout
);

    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] CMAX = CW'(MAX_HOLD - 1);
    localparam logic [CW-1:0] DMIN = CW'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    state_t        state;
    logic [3:0]    sel;
    logic [3:0]    last;
    logic [3:0]    win;
    logic [3:0]    idx;
    logic          found;
    logic [CW-1:0] cnt;
    logic          expire;
    logic          rel;

    // Scan starts just past the previous winner, so it ranks last.
    always_comb begin
        win   = last;
        idx   = last;
        found = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            idx = last + 4'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign expire = (cnt == CMAX);
    assign rel    = expire || !req[sel] || (done && cnt >= DMIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= 4'd0;
            last    <= 4'd15;
            grant   <= 16'd0;
            valid   <= 1'b0;
            timeout <= 1'b0;
            cnt     <= '0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        sel   <= win;
                        grant <= 16'd1 << win;
                        valid <= 1'b1;
                        last  <= win;
                        cnt   <= '0;
                        state <= OWN;
                    end else begin
`ifdef MUX_SCAN_EN
                        sel <= sel + 4'd1;
`else
                        sel <= sel;
`endif
                    end
                end
                OWN: begin
                    if (rel) begin
                        grant   <= 16'd0;
                        valid   <= 1'b0;
                        timeout <= expire;
                        state   <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign {S1, S2, S3, S4} = sel;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Scoreboard bench for mux_rr_sched (default DWELL=4, MAX_HOLD=16).
// Build with MUX_SCAN_EN to exercise the idle select sweep.
module tb_mux_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic        S1, S2, S3, S4;
    logic [15:0] grant;
    logic        valid;
    logic        timeout;

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_q[$];
    int model_last = 15;

    logic [15:0] mux_i = 16'hAAAA;
    logic [3:0]  sel_o;
    logic        mux_o;

    assign sel_o = {S1, S2, S3, S4};
    assign mux_o = mux_i[sel_o];

    mux_rr_sched dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .S1(S1), .S2(S2), .S3(S3), .S4(S4),
        .grant(grant), .valid(valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic int next_winner(logic [15:0] r, int lst);
        for (int i = 1; i <= 16; i++) begin
            if (r[(lst + i) % 16]) return (lst + i) % 16;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            total_cnt++;
            if (valid !== (|grant) || !$onehot0(grant))
                $display("FAIL grant_shape: valid=%b grant=%h",
                         valid, grant);
            else pass_cnt++;
        end
    end

    // Push the model's choice for the current req.
    task automatic push_exp();
        int w;
        w = next_winner(req, model_last);
        exp_q.push_back(w);
        model_last = w;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic settle();
        req  = 16'd0;
        done = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 16'd0;
        done = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (grant !== 16'd0 || valid !== 1'b0 || timeout !== 1'b0
            || sel_o !== 4'd0)
            $display("FAIL reset: g=%h v=%b t=%b s=%h want 0",
                     grant, valid, timeout, sel_o);
        else pass_cnt++;
        rst = 1'b0;
        model_last = 15;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n, e;
        req = 16'h0020;
        push_exp();
        wait_valid(n);
        e = exp_q.pop_front();
        total_cnt++;
        if (n !== 1 || grant !== (16'd1 << e) || sel_o !== 4'(e))
            $display("FAIL single: lat=%0d g=%h s=%h want 1 %h %h",
                     n, grant, sel_o, 16'd1 << e, e);
        else pass_cnt++;
        total_cnt++;
        if (sel_o !== 4'b0101 || mux_o !== 1'b1)
            $display("FAIL single_mux: s=%h o=%b want 5 1",
                     sel_o, mux_o);
        else pass_cnt++;
        settle();
    endtask

    task automatic test_round_robin();
        int n, e;
        req = 16'h8001;
        for (int g = 0; g < 4; g++) begin
            push_exp();
            wait_valid(n);
            e = exp_q.pop_front();
            total_cnt++;
            if (valid !== 1'b1 || grant !== (16'd1 << e))
                $display("FAIL rr_grant%0d: g=%h want %h",
                         g, grant, 16'd1 << e);
            else pass_cnt++;
            total_cnt++;
            if (n !== (g == 0 ? 1 : 2))
                $display("FAIL rr_gap%0d: got %0d want %0d",
                         g, n, g == 0 ? 1 : 2);
            else pass_cnt++;
            repeat (3) @(negedge clk);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            total_cnt++;
            if (valid !== 1'b0 || timeout !== 1'b0)
                $display("FAIL rr_release%0d: v=%b t=%b want 0 0",
                         g, valid, timeout);
            else pass_cnt++;
        end
        settle();
    endtask

    task automatic test_early_done();
        int n, e;
        req = 16'h0010;
        push_exp();
        wait_valid(n);
        e = exp_q.pop_front();
        total_cnt++;
        if (grant !== (16'd1 << e))
            $display("FAIL early_grant: g=%h want %h", grant, 16'd1 << e);
        else pass_cnt++;
        done = 1'b1;
        repeat (3) @(negedge clk);
        done = 1'b0;
        total_cnt++;
        if (valid !== 1'b1)
            $display("FAIL early_ignored: v=%b want 1", valid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (valid !== 1'b1)
            $display("FAIL early_not_kept: v=%b want 1", valid);
        else pass_cnt++;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        total_cnt++;
        if (valid !== 1'b0 || timeout !== 1'b0)
            $display("FAIL dwell_release: v=%b t=%b want 0 0",
                     valid, timeout);
        else pass_cnt++;
        settle();
    endtask

    task automatic test_timeout();
        int n, e, hold;
        req = 16'h0100;
        push_exp();
        wait_valid(n);
        e = exp_q.pop_front();
        hold = 0;
        while (valid === 1'b1 && hold < 40) begin
            hold++;
            @(negedge clk);
        end
        total_cnt++;
        if (hold !== 16 || e !== 8)
            $display("FAIL to_hold: got %0d idx %0d want 16 8", hold, e);
        else pass_cnt++;
        total_cnt++;
        if (timeout !== 1'b1)
            $display("FAIL to_pulse: t=%b want 1", timeout);
        else pass_cnt++;
        push_exp();
        @(negedge clk);
        total_cnt++;
        if (timeout !== 1'b0 || valid !== 1'b0)
            $display("FAIL to_width: t=%b v=%b want 0 0",
                     timeout, valid);
        else pass_cnt++;
        @(negedge clk);
        e = exp_q.pop_front();
        total_cnt++;
        if (valid !== 1'b1 || grant !== (16'd1 << e))
            $display("FAIL to_regrant: g=%h want %h", grant, 16'd1 << e);
        else pass_cnt++;
        settle();
    endtask

    task automatic test_withdraw_reset();
        int n, e;
        req = 16'h0008;
        push_exp();
        wait_valid(n);
        e = exp_q.pop_front();
        total_cnt++;
        if (grant !== (16'd1 << e) || e !== 3)
            $display("FAIL wd_grant: g=%h want 0008", grant);
        else pass_cnt++;
        @(negedge clk);
        req = 16'd0;
        @(negedge clk);
        total_cnt++;
        if (valid !== 1'b0 || timeout !== 1'b0)
            $display("FAIL wd_release: v=%b t=%b want 0 0",
                     valid, timeout);
        else pass_cnt++;
        req = 16'h0008;
        push_exp();
        wait_valid(n);
        e = exp_q.pop_front();
        total_cnt++;
        if (valid !== 1'b1 || grant !== (16'd1 << e))
            $display("FAIL wd_regrant: g=%h want %h", grant, 16'd1 << e);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (grant !== 16'd0 || valid !== 1'b0 || sel_o !== 4'd0)
            $display("FAIL async_reset: g=%h v=%b s=%h want 0 0 0",
                     grant, valid, sel_o);
        else pass_cnt++;
        @(negedge clk);
        model_last = 15;
        req = 16'hFFFF;
        rst = 1'b0;
        push_exp();
        wait_valid(n);
        e = exp_q.pop_front();
        total_cnt++;
        if (grant !== 16'h0001 || e !== 0)
            $display("FAIL post_reset: g=%h want 0001", grant);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        push_exp();
        wait_valid(n);
        e = exp_q.pop_front();
        total_cnt++;
        if (grant !== (16'd1 << e) || e !== 1)
            $display("FAIL post_reset_next: g=%h want 0002", grant);
        else pass_cnt++;
        settle();
    endtask

    task automatic test_idle_sel();
        int n, e;
        logic [3:0] s0;
        logic [3:0] es;
        s0 = sel_o;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
`ifdef MUX_SCAN_EN
            es = s0 + 4'(i);
`else
            es = 4'(model_last);
`endif
            total_cnt++;
            if (sel_o !== es || valid !== 1'b0)
                $display("FAIL idle_sel%0d: s=%h v=%b want %h 0",
                         i, sel_o, valid, es);
            else pass_cnt++;
        end
        req = 16'hFFFF;
        push_exp();
        wait_valid(n);
        e = exp_q.pop_front();
        total_cnt++;
        if (grant !== (16'd1 << e) || sel_o !== 4'(e))
            $display("FAIL idle_arb: g=%h s=%h want %h %h",
                     grant, sel_o, 16'd1 << e, e);
        else pass_cnt++;
        settle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_early_done();
        test_timeout();
        test_withdraw_reset();
        test_idle_sel();
        total_cnt++;
        if (exp_q.size() !== 0)
            $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
